// File: rtl/mem_pkg.sv
// mem_pkg: shared memory geometry and preload FSM state encoding
package mem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int MEM_DEPTH = 1000;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_t;
endpackage

// File: rtl/mem_preload_dma.sv
// mem_preload_dma: stream-to-memory burst preload engine; MEM_PRELOAD_CHECKSUM_EN adds a burst checksum output
module mem_preload_dma
  import mem_pkg::*;
#(
  parameter int DATA_W    = mem_pkg::DATA_W,
  parameter int ADDR_W    = mem_pkg::ADDR_W,
  parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              busy,
  output logic              done,
`ifdef MEM_PRELOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              err
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr, rem;
  logic [ADDR_W:0] end_addr;
  logic bad, accept;
  assign end_addr = {1'b0, base_addr} + {1'b0, word_count};
  assign bad = end_addr > DEPTH;
  assign accept = in_valid && in_ready;
  // state register
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= nxt;
  // next-state: range or empty bursts skip straight to FIN
  always_comb begin
    nxt = state;
    if (state == ST_IDLE) nxt = start ? ((bad || word_count == '0) ? ST_FIN : ST_LOAD) : ST_IDLE;
    else if (state == ST_LOAD) nxt = (accept && rem == ADDR_W'(1)) ? ST_FIN : ST_LOAD;
    else nxt = ST_IDLE;
  end
  // state-decoded outputs
  always_comb begin
    in_ready = state == ST_LOAD;
    busy = state == ST_LOAD;
  end
  // datapath: burst setup in IDLE, registered write port one cycle after acceptance
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      rem <= '0;
      err <= 1'b0;
      done <= 1'b0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      mem_waddr <= '0;
`ifdef MEM_PRELOAD_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      mem_we <= accept;
      done <= state == ST_FIN;
      if (state == ST_IDLE && start) begin
        ptr <= base_addr;
        rem <= word_count;
        err <= bad;
`ifdef MEM_PRELOAD_CHECKSUM_EN
        checksum <= '0;
`endif
      end else if (accept) begin
        mem_wdata <= in_data;
        mem_waddr <= ptr;
        ptr <= ptr + 1'b1;
        rem <= rem - 1'b1;
`ifdef MEM_PRELOAD_CHECKSUM_EN
        checksum <= checksum + in_data;
`endif
      end
    end
endmodule

// File: tb/tb_mem_preload_dma.sv
// tb_mem_preload_dma: directed scoreboard bench for mem_preload_dma
module tb_mem_preload_dma;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_wdata;
  logic [15:0] mem_waddr;
`ifdef MEM_PRELOAD_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  int w0, n;
  logic [15:0] exp_addr;
  logic [47:0] sb[$];

  mem_preload_dma dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_waddr(mem_waddr), .busy(busy), .done(done),
`ifdef MEM_PRELOAD_CHECKSUM_EN
    .checksum(checksum),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk)
    if (mem_we === 1'b1) begin
      writes++;
      if (sb.size() == 0) chk("unexpected_write", 64'(mem_waddr), 64'hFFFF_FFFF);
      else begin
        logic [47:0] e;
        e = sb.pop_front();
        chk("waddr", 64'(mem_waddr), 64'(e[47:32]));
        chk("wdata", 64'(mem_wdata), 64'(e[31:0]));
      end
    end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [15:0] b, input logic [15:0] c);
    base_addr = b;
    word_count = c;
    start = 1'b1;
    step;
    start = 1'b0;
    exp_addr = b;
  endtask

  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data = d;
    sb.push_back({exp_addr, d});
    exp_addr = exp_addr + 16'd1;
    step;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      step;
      cyc++;
    end
  endtask

  initial begin
    step;
    step;
    chk("rst_we", 64'(mem_we), 0);
    chk("rst_ready", 64'(in_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_waddr", 64'(mem_waddr), 0);
    reset = 1'b0;
    step;
    // 1: back-to-back burst
    w0 = writes;
    start_burst(16'd10, 16'd4);
    chk("t1_ready", 64'(in_ready), 1);
    chk("t1_busy", 64'(busy), 1);
    for (int i = 0; i < 4; i++) feed(32'hA0 + 32'(i));
    in_valid = 1'b0;
    chk("t1_ready_drop", 64'(in_ready), 0);
    wait_done(n);
    chk("t1_done_lat", 64'(n), 1);
    chk("t1_err", 64'(err), 0);
    step;
    chk("t1_done_pulse", 64'(done), 0);
    chk("t1_writes", 64'(writes - w0), 4);
    // 2: gapped stream
    w0 = writes;
    start_burst(16'd0, 16'd3);
    feed(32'hB0);
    in_valid = 1'b0;
    step;
    feed(32'hB1);
    in_valid = 1'b0;
    step;
    feed(32'hB2);
    in_valid = 1'b0;
    wait_done(n);
    chk("t2_done_lat", 64'(n), 1);
    step;
    chk("t2_writes", 64'(writes - w0), 3);
    // 3: out-of-range then exact fit at the top
    w0 = writes;
    start_burst(16'd998, 16'd3);
    chk("t3_ready", 64'(in_ready), 0);
    in_valid = 1'b1;
    in_data = 32'hDEAD;
    wait_done(n);
    in_valid = 1'b0;
    chk("t3_done_lat", 64'(n), 1);
    chk("t3_err", 64'(err), 1);
    step;
    chk("t3_err_hold", 64'(err), 1);
    chk("t3_nowrite", 64'(writes - w0), 0);
    start_burst(16'd997, 16'd3);
    chk("t3_err_clear", 64'(err), 0);
    for (int i = 0; i < 3; i++) feed(32'hC0 + 32'(i));
    in_valid = 1'b0;
    wait_done(n);
    chk("t3b_done_lat", 64'(n), 1);
    chk("t3b_err", 64'(err), 0);
    step;
    chk("t3b_writes", 64'(writes - w0), 3);
    // 4: empty burst
    w0 = writes;
    start_burst(16'd50, 16'd0);
    chk("t4_ready", 64'(in_ready), 0);
    chk("t4_busy", 64'(busy), 0);
    wait_done(n);
    chk("t4_done_lat", 64'(n), 1);
    chk("t4_ready_done", 64'(in_ready), 0);
    step;
    chk("t4_nowrite", 64'(writes - w0), 0);
    // 5: reset mid-burst
    w0 = writes;
    start_burst(16'd100, 16'd5);
    feed(32'hD0);
    feed(32'hD1);
    in_data = 32'hD2;
    reset = 1'b1;
    step;
    chk("t5_we", 64'(mem_we), 0);
    chk("t5_ready", 64'(in_ready), 0);
    chk("t5_busy", 64'(busy), 0);
    chk("t5_done", 64'(done), 0);
    chk("t5_waddr", 64'(mem_waddr), 0);
    chk("t5_wdata", 64'(mem_wdata), 0);
    reset = 1'b0;
    step;
    step;
    in_valid = 1'b0;
    chk("t5_writes", 64'(writes - w0), 2);
    w0 = writes;
    start_burst(16'd200, 16'd2);
    feed(32'hE0);
    feed(32'hE1);
    in_valid = 1'b0;
    wait_done(n);
    chk("t5b_done_lat", 64'(n), 1);
    step;
    chk("t5b_writes", 64'(writes - w0), 2);
    // 6: start re-pulse mid-burst, checksum wrap
    w0 = writes;
    start_burst(16'd300, 16'd2);
    feed(32'hFFFF_FFFF);
    in_valid = 1'b0;
    base_addr = 16'd500;
    word_count = 16'd7;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("t6_busy", 64'(busy), 1);
    feed(32'h2);
    in_valid = 1'b0;
    wait_done(n);
    chk("t6_done_lat", 64'(n), 1);
    chk("t6_err", 64'(err), 0);
`ifdef MEM_PRELOAD_CHECKSUM_EN
    chk("t6_checksum", 64'(checksum), 1);
`endif
    step;
    step;
    chk("t6_busy_after", 64'(busy), 0);
    chk("t6_writes", 64'(writes - w0), 2);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
